// File: rtl/pu_read_buffer.sv
// -----------------------------------------------------------------------------
// pu_read_buffer
//   Width-converting read buffer between a wide memory port and a processing
//   unit (PU). Each memory word carries RATIO PU words (PU word 0 in the low
//   bits). The memory side pushes whole memory words. The PU side pops one PU
//   word per accepted request, and the popped word is registered on read_data.
//
// Ports
//   clk         : single clock; all state changes on the rising edge
//   reset       : synchronous active-high reset (highest priority)
//   clear       : synchronous flush of buffered words between layers
//   wr_req      : memory-side write strobe
//   wr_data     : memory word, MEM_WIDTH bits
//   wr_ready    : a memory word can be accepted this cycle
//   read_req    : PU pop strobe
//   read_ready  : at least one PU word is available
//   read_data   : registered PU word, valid the cycle after an accepted pop
//   fill_count  : number of PU words available
//   overflow    : sticky, set by a write attempt while full
//   underflow   : sticky, set by a pop attempt while empty
// -----------------------------------------------------------------------------
module pu_read_buffer #(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   wr_req,
  input  logic [RATIO*NUM_PE*OP_WIDTH-1:0]       wr_data,
  output logic                                   wr_ready,
  input  logic                                   read_req,
  output logic                                   read_ready,
  output logic [NUM_PE*OP_WIDTH-1:0]             read_data,
  output logic [ADDR_WIDTH+$clog2(RATIO):0]      fill_count,
  output logic                                   overflow,
  output logic                                   underflow
);

  localparam int DATA_WIDTH = NUM_PE * OP_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LOG_R      = $clog2(RATIO);
  localparam int SUB_W      = (LOG_R > 0) ? LOG_R : 1;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int FC_W       = ADDR_WIDTH + LOG_R + 1;

  // Storage: each entry is one memory word viewed as RATIO PU words.
  logic [RATIO-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SUB_W-1:0]      sub_idx_q, sub_idx_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;
  logic rd_free;
  logic sub_last;

  // Status is derived purely from registered state, so neither request
  // strobe has a combinational path to the ready outputs. A pop that frees
  // an entry while full therefore cannot raise wr_ready in the same cycle.
  assign wr_ready   = (count_q < CNT_W'(DEPTH));
  assign fill_count = (FC_W'(count_q) << LOG_R) - FC_W'(sub_idx_q);
  assign read_ready = (fill_count != '0);
  assign sub_last   = (sub_idx_q == SUB_W'(RATIO - 1));

  assign read_data  = read_data_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sub_idx_d   = sub_idx_q;
    read_data_d = read_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    rd_free     = 1'b0;

    if (clear) begin
      // Flush discards buffered words and ignores both strobes; read_data
      // and the sticky flags survive so errors from a layer stay visible.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      sub_idx_d = '0;
    end else begin
      wr_acc = wr_req && wr_ready;
      rd_acc = read_req && read_ready;

      if (wr_req && !wr_ready)    overflow_d  = 1'b1;
      if (read_req && !read_ready) underflow_d = 1'b1;

      if (rd_acc) begin
        read_data_d = mem_q[rd_ptr_q][sub_idx_q];
        if (sub_last) begin
          // Last PU word of this entry consumed: release the entry.
          sub_idx_d = '0;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_free   = 1'b1;
        end else begin
          sub_idx_d = sub_idx_q + 1'b1;
        end
      end

      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;

      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_free);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sub_idx_q   <= '0;
      read_data_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sub_idx_q   <= sub_idx_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
